// File: rtl/sn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sn_pkg
//  Description : Shared definitions for the sorting-network output side.
//                Provides default geometry, the block-width constant, the
//                record-slice helper and the drain-state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sn_pkg;

  // Default geometry of the sorting network.
  localparam int SN_P_LOG_DEF    = 4;
  localparam int SN_DATW_DEF     = 64;
  localparam int SN_KEYW_DEF     = 32;
  localparam int SN_FIFO_LOG_DEF = 2;

  // A block is 2^P_LOG records laid side by side on one wide word.
  localparam int SN_BLKW_DEF = SN_DATW_DEF << SN_P_LOG_DEF;

  // Drain engine: IDLE holds no head block, DRAIN walks its lanes.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } sn_drain_e;

  // Width of one whole block in bits.
  function automatic int sn_blk_width(input int datw, input int p_log);
    return datw << p_log;
  endfunction

  // Least-significant bit of record 'rec' within a block word.
  function automatic int sn_rec_lsb(input int datw, input int rec);
    return datw * rec;
  endfunction

endpackage : sn_pkg
`default_nettype wire

// File: rtl/sn_unpack_if.sv
`default_nettype none
// ============================================================================
//  Module      : sn_unpack_if
//  Description : Bundle of the sorted-block input bus and the record-stream
//                output of sn_unpack.
//                DIN/DINEN : block word and its one-cycle strobe (no ready)
//                DOT/DOTEN/RDY/DLAST/DIDX : record stream, valid/ready
//                OVF/FCNT  : sticky drop flag and buffered-block count
//                slave  modport : the unpacker itself
//                master modport : network + downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
interface sn_unpack_if
  import sn_pkg::*;
#(
  parameter int P_LOG    = SN_P_LOG_DEF,
  parameter int DATW     = SN_DATW_DEF,
  parameter int FIFO_LOG = SN_FIFO_LOG_DEF
);

  logic [(DATW<<P_LOG)-1:0] DIN;
  logic                     DINEN;
  logic [DATW-1:0]          DOT;
  logic                     DOTEN;
  logic                     RDY;
  logic                     DLAST;
  logic [P_LOG-1:0]         DIDX;
  logic                     OVF;
  logic [FIFO_LOG:0]        FCNT;

  modport slave (
    input  DIN, DINEN, RDY,
    output DOT, DOTEN, DLAST, DIDX, OVF, FCNT
  );

  modport master (
    output DIN, DINEN, RDY,
    input  DOT, DOTEN, DLAST, DIDX, OVF, FCNT
  );

endinterface : sn_unpack_if
`default_nettype wire

// File: rtl/sn_blkfifo.sv
`default_nettype none
// ============================================================================
//  Module      : sn_blkfifo
//  Description : Block FIFO of WIDTH-bit entries, 2^DEPTH_LOG deep, with
//                full/empty/count status and a combinational head output.
//                clk_i/rst_n_i : clock, async active-low reset
//                push_i/wdata_i: write enable and data (caller guarantees
//                                push only when not full or popping)
//                pop_i         : retire the head entry
//                rdata_o       : head entry
//                full_o/empty_o/count_o : occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module sn_blkfifo
  import sn_pkg::*;
#(
  parameter int WIDTH     = SN_BLKW_DEF,
  parameter int DEPTH_LOG = SN_FIFO_LOG_DEF
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_n_i,
  input  wire logic                 push_i,
  input  wire logic [WIDTH-1:0]     wdata_i,
  input  wire logic                 pop_i,
  output logic      [WIDTH-1:0]     rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic      [DEPTH_LOG:0]   count_o
);

  localparam int                   DEPTH   = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG:0]   CNT_MAX = DEPTH[DEPTH_LOG:0];

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG:0]   cnt_q,  cnt_d;

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop_i) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // When full and popping, the write lands in the slot being read; the
  // read sees the old contents because the write only takes effect at the edge.
  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule : sn_blkfifo
`default_nettype wire

// File: rtl/sn_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : sn_unpack
//  Description : Receiving end of the sorting network. Buffers whole sorted
//                blocks in a block FIFO and streams their records out one per
//                cycle, lane 0 first, on a valid/ready interface. Blocks that
//                arrive while the FIFO is full are dropped and flagged.
//                CLK   : clock, rising edge
//                RST_X : async active-low reset
//                bus   : DIN/DINEN in, DOT/DOTEN/RDY/DLAST/DIDX out stream,
//                        OVF sticky drop flag, FCNT buffered-block count
//  Revision    : 1.0 - initial release
// ============================================================================
module sn_unpack
  import sn_pkg::*;
#(
  parameter int P_LOG    = SN_P_LOG_DEF,
  parameter int DATW     = SN_DATW_DEF,
  parameter int KEYW     = SN_KEYW_DEF,
  parameter int FIFO_LOG = SN_FIFO_LOG_DEF
) (
  input  wire logic  CLK,
  input  wire logic  RST_X,
  sn_unpack_if.slave bus
);

  localparam int               BLKW     = sn_blk_width(DATW, P_LOG);
  localparam int               NLANE    = 1 << P_LOG;
  localparam logic [P_LOG-1:0] LANE_ONE = 1;
  localparam logic [P_LOG-1:0] LANE_MAX = '1;
  localparam logic [FIFO_LOG:0] CNT_ONE = 1;

  // The key field is carried inside the record untouched; it only has to fit.
  if (KEYW < 1 || KEYW > DATW) begin : g_keyw_bad
    $error("sn_unpack: KEYW must lie in 1..DATW");
  end

  // --------------------------------------------------------------------------
  // Block FIFO
  // --------------------------------------------------------------------------
  logic [BLKW-1:0]   w_head;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_LOG:0] w_fcnt;
  logic              w_push;
  logic              w_pop;

  sn_blkfifo #(
    .WIDTH     (BLKW),
    .DEPTH_LOG (FIFO_LOG)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_X),
    .push_i  (w_push),
    .wdata_i (bus.DIN),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_fcnt)
  );

  // --------------------------------------------------------------------------
  // Lane mux: split the head block into its records
  // --------------------------------------------------------------------------
  logic [DATW-1:0] w_lanes [NLANE];

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    assign w_lanes[g] = w_head[sn_rec_lsb(DATW, g) +: DATW];
  end

  // --------------------------------------------------------------------------
  // Drain engine state
  // --------------------------------------------------------------------------
  sn_drain_e         state_q, state_d;
  logic [P_LOG-1:0]  lane_q,  lane_d;
  logic [DATW-1:0]   dot_q,   dot_d;
  logic              doten_q, doten_d;
  logic              dlast_q, dlast_d;
  logic [P_LOG-1:0]  didx_q,  didx_d;
  logic              ovf_q,   ovf_d;

  logic              w_avail;
  logic              w_slot_free;
  logic              w_load;
  logic              w_last_lane;
  logic              w_head_stays;

  // The output register is a one-entry pipeline stage: it may refill
  // whenever it is empty or its current record is being taken.
  assign w_avail     = (state_q == ST_DRAIN);
  assign w_slot_free = !doten_q || bus.RDY;
  assign w_load      = w_slot_free && w_avail;
  assign w_last_lane = (lane_q == LANE_MAX);

  // The head block stays in the FIFO until its last lane is loaded.
  assign w_pop  = w_load && w_last_lane;
  // A full FIFO still takes a block when the head retires on the same edge.
  assign w_push = bus.DINEN && (!w_full || w_pop);

  // Some block remains at the head after this edge, ignoring a new push.
  assign w_head_stays = !w_empty && !(w_pop && (w_fcnt == CNT_ONE));

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    dot_d   = dot_q;
    doten_d = doten_q;
    dlast_d = dlast_q;
    didx_d  = didx_q;
    ovf_d   = ovf_q;

    state_d = (w_push || w_head_stays) ? ST_DRAIN : ST_IDLE;

    if (bus.DINEN && !w_push) begin
      ovf_d = 1'b1;
    end

    if (w_load) begin
      dot_d   = w_lanes[lane_q];
      didx_d  = lane_q;
      dlast_d = w_last_lane;
      doten_d = 1'b1;
      // Wraps to 0 naturally after the last lane.
      lane_d  = lane_q + LANE_ONE;
    end else if (w_slot_free) begin
      doten_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      dot_q   <= '0;
      doten_q <= 1'b0;
      dlast_q <= 1'b0;
      didx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      dot_q   <= dot_d;
      doten_q <= doten_d;
      dlast_q <= dlast_d;
      didx_q  <= didx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.DOT   = dot_q;
  assign bus.DOTEN = doten_q;
  assign bus.DLAST = dlast_q;
  assign bus.DIDX  = didx_q;
  assign bus.OVF   = ovf_q;
  assign bus.FCNT  = w_fcnt;

endmodule : sn_unpack
`default_nettype wire

// File: tb/tb_sn_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn_unpack
//  Description : Self-checking bench for sn_unpack (P_LOG=2, DATW=8,
//                FIFO_LOG=1). Expected records are queued when a block is
//                driven and compared as the stream produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sn_unpack;

  localparam int P_LOG    = 2;
  localparam int DATW     = 8;
  localparam int KEYW     = 8;
  localparam int FIFO_LOG = 1;

  logic CLK;
  logic RST_X;

  int n_checks = 0;
  int n_errors = 0;

  // {last, idx[1:0], data[7:0]}
  logic [10:0] sb [$];

  sn_unpack_if #(.P_LOG(P_LOG), .DATW(DATW), .FIFO_LOG(FIFO_LOG)) bus ();

  sn_unpack #(
    .P_LOG    (P_LOG),
    .DATW     (DATW),
    .KEYW     (KEYW),
    .FIFO_LOG (FIFO_LOG)
  ) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one block for a single cycle; queue its records if it should land.
  task automatic send_block(input logic [31:0] blk, input bit accept);
    logic [31:0] b;
    b = blk;
    bus.DIN   = b;
    bus.DINEN = 1'b1;
    if (accept) begin
      for (int r = 0; r < 4; r++) begin
        sb.push_back({(r == 3), 2'(r), b[8*r +: 8]});
      end
    end
    tick();
    bus.DINEN = 1'b0;
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    sb.delete();
    tick();
    tick();
    RST_X = 1'b1;
  endtask

  // Stream monitor: sampled on the falling edge, well away from the active one.
  always @(negedge CLK) begin
    logic [10:0] e;
    if (RST_X && bus.DOTEN) begin
      check("sb_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        if (bus.RDY) begin
          e = sb.pop_front();
          check("xfer_dot",   32'(bus.DOT),   32'(e[7:0]));
          check("xfer_didx",  32'(bus.DIDX),  32'(e[9:8]));
          check("xfer_dlast", 32'(bus.DLAST), 32'(e[10]));
        end else begin
          e = sb[0];
          check("hold_dot",  32'(bus.DOT),  32'(e[7:0]));
          check("hold_didx", 32'(bus.DIDX), 32'(e[9:8]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_X     = 1'b0;
    bus.DIN   = '0;
    bus.DINEN = 1'b0;
    bus.RDY   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_doten", 32'(bus.DOTEN), 0);
    check("rst_dot",   32'(bus.DOT),   0);
    check("rst_didx",  32'(bus.DIDX),  0);
    check("rst_dlast", 32'(bus.DLAST), 0);
    check("rst_ovf",   32'(bus.OVF),   0);
    check("rst_fcnt",  32'(bus.FCNT),  0);
    RST_X = 1'b1;
    tick();

    // Single block, one-edge latency
    bus.RDY = 1'b1;
    send_block(32'h40302010, 1'b1);
    check("t1_lat_doten0", 32'(bus.DOTEN), 0);
    check("t1_fcnt_push",  32'(bus.FCNT),  1);
    tick();
    check("t1_lat_doten1", 32'(bus.DOTEN), 1);
    check("t1_lane0",      32'(bus.DIDX),  0);
    check("t1_fcnt_head",  32'(bus.FCNT),  1);
    repeat (4) tick();
    check("t1_idle_doten", 32'(bus.DOTEN), 0);
    check("t1_idle_fcnt",  32'(bus.FCNT),  0);
    check("t1_sb_empty",   32'(sb.size()), 0);

    // Backpressure on the first record
    send_block(32'h40302010, 1'b1);
    tick();
    bus.RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_dot",  32'(bus.DOT),  32'h10);
      check("t2_hold_didx", 32'(bus.DIDX), 0);
      tick();
    end
    bus.RDY = 1'b1;
    repeat (4) tick();
    check("t2_idle_doten", 32'(bus.DOTEN), 0);
    check("t2_sb_empty",   32'(sb.size()), 0);

    // Back-to-back blocks, no bubble
    send_block(32'h04030201, 1'b1);
    send_block(32'h08070605, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("t3_nobubble", 32'(bus.DOTEN), 1);
      tick();
    end
    check("t3_idle_doten", 32'(bus.DOTEN), 0);
    check("t3_ovf",        32'(bus.OVF),   0);
    check("t3_sb_empty",   32'(sb.size()), 0);

    // Overflow: third block dropped while stalled
    bus.RDY = 1'b0;
    send_block(32'h14131211, 1'b1);
    send_block(32'h24232221, 1'b1);
    check("t4_fcnt_full", 32'(bus.FCNT), 2);
    check("t4_ovf_pre",   32'(bus.OVF),  0);
    send_block(32'h34333231, 1'b0);
    check("t4_fcnt_peak", 32'(bus.FCNT), 2);
    check("t4_ovf_set",   32'(bus.OVF),  1);
    bus.RDY = 1'b1;
    repeat (8) tick();
    check("t4_idle_doten", 32'(bus.DOTEN), 0);
    check("t4_fcnt_end",   32'(bus.FCNT),  0);
    check("t4_ovf_sticky", 32'(bus.OVF),   1);
    check("t4_sb_empty",   32'(sb.size()), 0);

    // Push into a full FIFO on the edge the head retires
    do_reset();
    check("t5_ovf_clr", 32'(bus.OVF), 0);
    bus.RDY = 1'b1;
    send_block(32'h44434241, 1'b1);
    send_block(32'h54535251, 1'b1);
    check("t5_fcnt_full", 32'(bus.FCNT), 2);
    tick();
    tick();
    send_block(32'h64636261, 1'b1);
    check("t5_fcnt_kept", 32'(bus.FCNT), 2);
    check("t5_ovf",       32'(bus.OVF),  0);
    repeat (9) tick();
    check("t5_idle_doten", 32'(bus.DOTEN), 0);
    check("t5_fcnt_end",   32'(bus.FCNT),  0);
    check("t5_sb_empty",   32'(sb.size()), 0);

    // Asynchronous reset mid-drain, with OVF set first
    send_block(32'h74737271, 1'b1);
    send_block(32'h84838281, 1'b1);
    send_block(32'h94939291, 1'b0);
    check("t6_didx1", 32'(bus.DIDX), 1);
    check("t6_ovf1",  32'(bus.OVF),  1);
    check("t6_fcnt2", 32'(bus.FCNT), 2);
    #2;
    RST_X = 1'b0;
    sb.delete();
    #1;
    check("t6_async_doten", 32'(bus.DOTEN), 0);
    check("t6_async_fcnt",  32'(bus.FCNT),  0);
    check("t6_async_ovf",   32'(bus.OVF),   0);
    tick();
    RST_X = 1'b1;
    tick();
    send_block(32'hA4A3A2A1, 1'b1);
    tick();
    check("t6_new_lane0", 32'(bus.DIDX), 0);
    check("t6_new_dot",   32'(bus.DOT),  32'hA1);
    repeat (4) tick();
    check("t6_idle_doten", 32'(bus.DOTEN), 0);
    check("t6_sb_empty",   32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sn_unpack
`default_nettype wire
